// File: rtl/upcount_pkg.sv
// Shared definitions for the up-counter command sequencer: default widths and
// the sequencer state encoding.
package upcount_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Status flags that travel together and are reported alongside done.
  typedef struct packed {
    logic err;
    logic wrap;
    logic aborted;
  } status_t;

endpackage

// File: rtl/upcount.sv
// Loadable up-counter driven by the sequencer: synchronous active-low reset,
// load has priority over enable.
import upcount_pkg::*;

module upcount #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] R,
  input  logic             L,
  input  logic             E,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      Q <= '0;
    end else if (L) begin
      Q <= R;
    end else if (E) begin
      Q <= Q + 1'b1;
    end
  end

endmodule

// File: rtl/upcount_runlen.sv
// Loadable run-length down-counter. Saturates at zero so a stray decrement
// can never wrap it around.
import upcount_pkg::*;

module upcount_runlen #(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             load,
  input  logic             dec,
  input  logic [LEN_W-1:0] din,
  output logic [LEN_W-1:0] cnt,
  output logic             zero,
  output logic             last
);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= din;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // last marks the final enabled cycle of a run.
  assign zero = (cnt == '0);
  assign last = (cnt == LEN_W'(1));

endmodule

// File: rtl/upcount_seq.sv
// Command sequencer for the loadable up-counter: load once, enable for len
// cycles, then verify the counter's load and final value and report status.
import upcount_pkg::*;

module upcount_seq #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             Clock,
  input  logic             Resetn,
  // Handshake: a command transfers on a posedge where cmd_valid and cmd_ready
  // are both high; cmd_ready is high only in IDLE and never depends on inputs.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             L,
  output logic             E,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wrap,
  output logic             aborted,
  output logic [WIDTH-1:0] q_final,
  output logic [2:0]       dbg_state
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] start_q;
  logic [LEN_W-1:0] len_q;
  logic [WIDTH-1:0] qf_r;
  logic [WIDTH-1:0] target;
  status_t          stat_r;
  logic             accept;
  logic             load_bad;
  logic             final_bad;
  logic             run_load;
  logic             run_dec;
  logic [LEN_W-1:0] run_cnt;
  logic             run_zero;
  logic             run_last;

  assign accept   = (state == ST_IDLE) && cmd_valid;
  assign load_bad = (Q != start_q);
  assign target   = start_q + WIDTH'(len_q);
  assign run_load = (state == ST_CHECK);
  assign run_dec  = (state == ST_RUN);

  upcount_runlen #(.LEN_W(LEN_W)) u_runlen (
    .Clock  (Clock),
    .Resetn (Resetn),
    .load   (run_load),
    .dec    (run_dec),
    .din    (len_q),
    .cnt    (run_cnt),
    .zero   (run_zero),
    .last   (run_last)
  );

  // State register
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = abort ? ST_DONE : ST_CHECK;
      ST_CHECK: begin
        if (abort || load_bad || (len_q == '0)) state_nxt = ST_DONE;
        else                                   state_nxt = ST_RUN;
      end
      ST_RUN:   if (abort || run_last || run_zero) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state flops only
  always_comb begin
    L         = (state == ST_LOAD);
    E         = (state == ST_RUN);
    R         = (state == ST_LOAD) ? start_q : '0;
    busy      = (state != ST_IDLE);
    cmd_ready = (state == ST_IDLE);
    done      = (state == ST_DONE);
    dbg_state = state;
  end

  // The final value is only meaningful on an unaborted run whose load checked out.
  assign final_bad = (state == ST_DONE) && !stat_r.aborted && !stat_r.err && (Q != target);

  assign err     = stat_r.err | final_bad;
  assign wrap    = stat_r.wrap;
  assign aborted = stat_r.aborted;
  assign q_final = (state == ST_DONE) ? Q : qf_r;

  // Command capture, sticky flags and held results
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      start_q <= '0;
      len_q   <= '0;
      qf_r    <= '0;
      stat_r  <= '0;
    end else begin
      if (accept) begin
        start_q <= cmd_start;
        len_q   <= cmd_len;
        stat_r  <= '0;
      end
      if ((state == ST_LOAD || state == ST_CHECK || state == ST_RUN) && abort) begin
        stat_r.aborted <= 1'b1;
      end
      if (state == ST_CHECK && load_bad) begin
        stat_r.err <= 1'b1;
      end
      if (state == ST_RUN && (Q == '1)) begin
        stat_r.wrap <= 1'b1;
      end
      // Hold the reported values after the done pulse ends.
      if (state == ST_DONE) begin
        qf_r       <= Q;
        stat_r.err <= err;
      end
    end
  end

endmodule
